// File: rtl/ec_serial_test_bridge.sv
// ---------------------------------------------------------------------------
// ec_serial_test_bridge
//
// Serial-to-parallel test bridge for exercising a start/done EC core from two
// pins. A framed serial word (MSB first) is deserialised, presented to the core
// with a one-cycle start pulse, the core result is captured on done (or after a
// timeout), and a status header plus the result is serialised back out.
//
// Output frame, MSB first: {perr, tmo, dut_out[OUT_WIDTH-1:0]} (+ parity bit).
//
// Optional feature macro: EC_BRIDGE_PARITY_EN
//   defined   : input frame carries a trailing even-parity bit over the data;
//               a mismatch skips the core and reports perr=1 with zero data.
//               The output frame gets a trailing even-parity bit.
//   undefined : no parity bits; perr is always 0.
//
// Parameters
//   IN_WIDTH   data bits per input frame (>= 3)
//   OUT_WIDTH  result bits captured from the core
//   TMO_CYC    WAIT cycles before timeout (>= 2)
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   test_i     serial input bit, MSB first
//   test_iv    test_i valid qualifier
//   test_o     serial output bit, MSB first
//   test_ov    high for the whole output frame
//   busy       high in every state except IDLE/SHIFT_IN
//   dut_in     parallel word to core, held from APPLY until the next frame
//   dut_start  one-cycle start pulse to the core
//   dut_done   core completion, only looked at in WAIT
//   dut_out    core result, sampled in the WAIT exit cycle
// ---------------------------------------------------------------------------
module ec_serial_test_bridge #(
  parameter int IN_WIDTH  = 166,
  parameter int OUT_WIDTH = 327,
  parameter int TMO_CYC   = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 test_i,
  input  logic                 test_iv,
  output logic                 test_o,
  output logic                 test_ov,
  output logic                 busy,
  output logic [IN_WIDTH-1:0]  dut_in,
  output logic                 dut_start,
  input  logic                 dut_done,
  input  logic [OUT_WIDTH-1:0] dut_out
);

`ifdef EC_BRIDGE_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  localparam int IN_FRAME  = IN_WIDTH + PAR_W;
  localparam int OUT_FRAME = OUT_WIDTH + 2 + PAR_W;
  // Without parity the last data bit goes straight into dut_in, so the
  // shift register only ever needs to hold the preceding bits.
  localparam int SR_W      = IN_FRAME - 1;
  localparam int ICW       = $clog2(IN_FRAME);
  localparam int OCW       = $clog2(OUT_FRAME);
  localparam int TCW       = $clog2(TMO_CYC);

  localparam logic [OCW-1:0] OUT_LAST = OCW'(OUT_FRAME - 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TMO_CYC - 1);
`ifdef EC_BRIDGE_PARITY_EN
  localparam logic [ICW-1:0] IN_PAR_IDX   = ICW'(IN_WIDTH);
`else
  localparam logic [ICW-1:0] IN_DATA_LAST = ICW'(IN_WIDTH - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_APPLY,
    S_WAIT,
    S_CAPTURE,
    S_SHIFT_OUT
  } state_t;

  state_t                 state_q,  state_d;
  logic [ICW-1:0]         icnt_q,   icnt_d;
  logic [TCW-1:0]         tcnt_q,   tcnt_d;
  logic [OCW-1:0]         ocnt_q,   ocnt_d;
  logic [SR_W-1:0]        sreg_q,   sreg_d;
  logic [IN_WIDTH-1:0]    dut_in_q, dut_in_d;
  logic [OUT_WIDTH-1:0]   data_q,   data_d;
  logic [OUT_FRAME-1:0]   osr_q,    osr_d;
  logic                   tmo_q,    tmo_d;
  logic                   perr_q,   perr_d;
  logic [SR_W-1:0]        sreg_shift;

  assign sreg_shift = {sreg_q[SR_W-2:0], test_i};
  assign dut_in     = dut_in_q;

  // Control state: reset returns everything observable to its idle value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      icnt_q   <= '0;
      tcnt_q   <= '0;
      ocnt_q   <= '0;
      dut_in_q <= '0;
      tmo_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      icnt_q   <= icnt_d;
      tcnt_q   <= tcnt_d;
      ocnt_q   <= ocnt_d;
      dut_in_q <= dut_in_d;
      tmo_q    <= tmo_d;
      perr_q   <= perr_d;
    end
  end

  // Datapath shift/capture registers: contents only matter once the control
  // path has marked them valid, so they carry no reset.
  always_ff @(posedge clk) begin
    sreg_q <= sreg_d;
    data_q <= data_d;
    osr_q  <= osr_d;
  end

  always_comb begin
    state_d   = state_q;
    icnt_d    = icnt_q;
    tcnt_d    = tcnt_q;
    ocnt_d    = ocnt_q;
    sreg_d    = sreg_q;
    dut_in_d  = dut_in_q;
    data_d    = data_q;
    osr_d     = osr_q;
    tmo_d     = tmo_q;
    perr_d    = perr_q;
    test_o    = 1'b0;
    test_ov   = 1'b0;
    busy      = 1'b1;
    dut_start = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        // The qualifying bit that wakes us up is already frame bit 0.
        if (test_iv) begin
          sreg_d  = sreg_shift;
          icnt_d  = ICW'(1);
          state_d = S_SHIFT_IN;
        end
      end

      S_SHIFT_IN: begin
        busy = 1'b0;
        if (test_iv) begin
`ifdef EC_BRIDGE_PARITY_EN
          if (icnt_q == IN_PAR_IDX) begin
            icnt_d = '0;
            if ((^sreg_q) ^ test_i) begin
              // Corrupt frame: report it without ever starting the core.
              perr_d  = 1'b1;
              tmo_d   = 1'b0;
              data_d  = '0;
              state_d = S_CAPTURE;
            end else begin
              perr_d   = 1'b0;
              dut_in_d = sreg_q;
              state_d  = S_APPLY;
            end
          end else begin
            sreg_d = sreg_shift;
            icnt_d = icnt_q + ICW'(1);
          end
`else
          if (icnt_q == IN_DATA_LAST) begin
            icnt_d   = '0;
            perr_d   = 1'b0;
            dut_in_d = {sreg_q, test_i};
            state_d  = S_APPLY;
          end else begin
            sreg_d = sreg_shift;
            icnt_d = icnt_q + ICW'(1);
          end
`endif
        end
      end

      S_APPLY: begin
        dut_start = 1'b1;
        tcnt_d    = '0;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        // Done is checked before the terminal count so that a late done wins.
        if (dut_done) begin
          data_d  = dut_out;
          tmo_d   = 1'b0;
          state_d = S_CAPTURE;
        end else if (tcnt_q == TMO_LAST) begin
          data_d  = dut_out;
          tmo_d   = 1'b1;
          state_d = S_CAPTURE;
        end else begin
          tcnt_d = tcnt_q + TCW'(1);
        end
      end

      S_CAPTURE: begin
`ifdef EC_BRIDGE_PARITY_EN
        osr_d = {perr_q, tmo_q, data_q, ^{perr_q, tmo_q, data_q}};
`else
        osr_d = {perr_q, tmo_q, data_q};
`endif
        ocnt_d  = '0;
        state_d = S_SHIFT_OUT;
      end

      S_SHIFT_OUT: begin
        test_ov = 1'b1;
        test_o  = osr_q[OUT_FRAME-1];
        osr_d   = {osr_q[OUT_FRAME-2:0], 1'b0};
        if (ocnt_q == OUT_LAST) begin
          ocnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          ocnt_d = ocnt_q + OCW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ec_serial_test_bridge.sv
// ---------------------------------------------------------------------------
// tb_ec_serial_test_bridge
//
// Directed and randomised transactions against ec_serial_test_bridge with a
// small configuration (IN=8, OUT=8, TMO=16). Expected frames are built from
// the bridge's externally visible rules: header {perr,tmo}, result sampled
// in the first cycle that done is seen in WAIT or in the last WAIT cycle,
// optional trailing even parity.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ec_serial_test_bridge;

  localparam int IN_W  = 8;
  localparam int OUT_W = 8;
  localparam int TMO   = 16;
`ifdef EC_BRIDGE_PARITY_EN
  localparam int PAR   = 1;
`else
  localparam int PAR   = 0;
`endif
  localparam int IN_F  = IN_W + PAR;
  localparam int OF    = OUT_W + 2 + PAR;

  logic             clk = 1'b0;
  logic             rst;
  logic             test_i;
  logic             test_iv;
  logic             test_o;
  logic             test_ov;
  logic             busy;
  logic [IN_W-1:0]  dut_in;
  logic             dut_start;
  logic             dut_done;
  logic [OUT_W-1:0] dut_out;

  int checks   = 0;
  int failures = 0;

  ec_serial_test_bridge #(
    .IN_WIDTH (IN_W),
    .OUT_WIDTH(OUT_W),
    .TMO_CYC  (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .test_i   (test_i),
    .test_iv  (test_iv),
    .test_o   (test_o),
    .test_ov  (test_ov),
    .busy     (busy),
    .dut_in   (dut_in),
    .dut_start(dut_start),
    .dut_done (dut_done),
    .dut_out  (dut_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Assert reset for one edge and confirm every output is back at idle.
  task automatic do_reset(input string tag);
    rst      = 1'b1;
    test_iv  = 1'b0;
    dut_done = 1'b0;
    tick;
    chk({tag, "_ctl"}, {test_o, test_ov, busy, dut_start}, 4'b0000);
    chk({tag, "_din"}, dut_in, '0);
    rst = 1'b0;
  endtask

  // One complete transaction.
  //   done_after : WAIT cycle index at which the core raises done (held), -1 = never
  //   fixed      : value driven on dut_out every cycle, -1 = random each cycle
  //   abort      : 0 none, 1 reset in WAIT cycle 2, 2 reset after 4th output bit
  task automatic run_txn(input logic [IN_W-1:0] din, input bit badpar,
                         input int done_after, input bit apply_done,
                         input bit gapped, input bit noise, input int fixed,
                         input int abort, output logic [OF-1:0] rx);
    logic [IN_F-1:0]  frame;
    logic [OF-1:0]    exp;
    logic [OUT_W-1:0] exp_data;
    logic             exp_tmo;
    logic             exp_perr;
`ifdef EC_BRIDGE_PARITY_EN
    frame    = {din, (^din) ^ badpar};
    exp_perr = badpar;
`else
    frame    = din;
    exp_perr = 1'b0;
`endif
    rx       = '0;
    exp_data = '0;
    exp_tmo  = 1'b0;

    for (int i = IN_F - 1; i >= 0; i--) begin
      test_iv = 1'b1;
      test_i  = frame[i];
      tick;
      if (gapped && i > 0) begin
        test_iv = 1'b0;
        test_i  = 1'($urandom);
        tick;
      end
    end
    test_iv = 1'b0;
    test_i  = 1'b0;

    if (!exp_perr) begin
      chk("apply_start", dut_start, 1'b1);
      chk("apply_din", dut_in, din);
      chk("apply_busy", {busy, test_ov}, 2'b10);
      dut_done = apply_done;
      tick;
      for (int w = 0; w < TMO; w++) begin
        dut_done = (done_after >= 0) && (w >= done_after);
        dut_out  = (fixed >= 0) ? OUT_W'(fixed) : OUT_W'($urandom);
        chk("wait_quiet", {test_ov, dut_start, busy}, 3'b001);
        if (abort == 1 && w == 2) begin
          do_reset("rst_wait");
          return;
        end
        if (dut_done || w == TMO - 1) begin
          exp_data = dut_out;
          exp_tmo  = !dut_done;
          tick;
          break;
        end
        tick;
      end
    end else begin
      chk("perr_nostart", dut_start, 1'b0);
    end

    dut_done = 1'b0;
    dut_out  = OUT_W'($urandom);
    chk("capture", {test_ov, busy, dut_start}, 3'b010);
`ifdef EC_BRIDGE_PARITY_EN
    exp = {exp_perr, exp_tmo, exp_data, ^{exp_perr, exp_tmo, exp_data}};
`else
    exp = {exp_perr, exp_tmo, exp_data};
`endif

    for (int j = 0; j < OF; j++) begin
      tick;
      chk("out_valid", {test_ov, busy}, 2'b11);
      chk("out_bit", test_o, exp[OF-1-j]);
      rx[OF-1-j] = test_o;
      if (abort == 2 && j == 3) begin
        do_reset("rst_shout");
        return;
      end
      if (noise) begin
        test_iv = 1'($urandom);
        test_i  = 1'($urandom);
      end
    end
    tick;
    test_iv = 1'b0;
    test_i  = 1'b0;
    chk("back_idle", {test_ov, busy, test_o}, 3'b000);
    chk("frame", rx, exp);
  endtask

  logic [OF-1:0]   rx;
  logic [OF-1:0]   lit;
  logic [IN_W-1:0] rdin;
  int              rdone;

  initial begin
    rst      = 1'b1;
    test_i   = 1'b0;
    test_iv  = 1'b0;
    dut_done = 1'b0;
    dut_out  = '0;
    repeat (3) tick;
    chk("reset_ctl", {test_o, test_ov, busy, dut_start}, 4'b0000);
    chk("reset_din", dut_in, '0);
    rst = 1'b0;
    tick;

    // Basic run: 0xA5 in, core answers 0x3C on WAIT cycle 5.
    run_txn(8'hA5, 1'b0, 5, 1'b0, 1'b0, 1'b0, 'h3C, 0, rx);
`ifdef EC_BRIDGE_PARITY_EN
    lit = 11'b00_00111100_0;
`else
    lit = 10'b00_00111100;
`endif
    chk("t1_literal", rx, lit);
    chk("t1_din_hold", dut_in, 8'hA5);

    // Core never answers: timeout after the full WAIT window.
    run_txn(8'h5E, 1'b0, -1, 1'b0, 1'b0, 1'b0, -1, 0, rx);
    chk("t2_header", rx[OF-1 -: 2], 2'b01);

    // Gapped input with test_iv noise during the output frame.
    run_txn(8'hC3, 1'b0, 2, 1'b0, 1'b1, 1'b1, -1, 0, rx);
    chk("t3_din", dut_in, 8'hC3);

    // Done on the terminal WAIT cycle beats the timeout; done in APPLY ignored.
    run_txn(8'h81, 1'b0, TMO - 1, 1'b1, 1'b0, 1'b0, -1, 0, rx);
    chk("t5_header", rx[OF-1 -: 2], 2'b00);
    run_txn(8'h7F, 1'b0, 6, 1'b1, 1'b0, 1'b0, -1, 0, rx);

    // Resets in WAIT and in SHIFT_OUT, each followed by a clean frame.
    run_txn(8'h11, 1'b0, 10, 1'b0, 1'b0, 1'b0, -1, 1, rx);
    tick;
    run_txn(8'h22, 1'b0, 1, 1'b0, 1'b0, 1'b0, -1, 0, rx);
    run_txn(8'h33, 1'b0, 0, 1'b0, 1'b0, 1'b0, -1, 2, rx);
    tick;
    run_txn(8'h44, 1'b0, 3, 1'b0, 1'b1, 1'b0, -1, 0, rx);

    // Reset mid input frame must discard the partial bits.
    for (int i = 0; i < 3; i++) begin
      test_iv = 1'b1;
      test_i  = 1'b1;
      tick;
    end
    do_reset("rst_shin");
    tick;
    run_txn(8'h0F, 1'b0, 4, 1'b0, 1'b0, 1'b0, -1, 0, rx);
    chk("rst_shin_din", dut_in, 8'h0F);

`ifdef EC_BRIDGE_PARITY_EN
    // Bad parity: no core start, perr header, zero data, output parity 1.
    run_txn(8'hA5, 1'b1, 0, 1'b0, 1'b0, 1'b0, -1, 0, rx);
    chk("t6_bad", rx, 11'b10_00000000_1);
    run_txn(8'hA5, 1'b0, 2, 1'b0, 1'b0, 1'b0, 'h3C, 0, rx);
    chk("t6_good", rx, 11'b00_00111100_0);
`endif

    // Randomised transactions.
    for (int n = 0; n < 10; n++) begin
      rdin  = IN_W'($urandom);
      rdone = $urandom_range(0, 20);
      if (rdone > 17) rdone = -1;
      run_txn(rdin, (PAR == 1) && ($urandom_range(0, 3) == 0), rdone,
              1'($urandom), 1'($urandom), 1'($urandom), -1, 0, rx);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
